// File: rtl/dphy_lane_pkg.sv
// Shared types and constants for the D-PHY data lane sequencer.
// State encoding, LP line levels and default lane timing.
package dphy_lane_pkg;

  // Gray-like walk through the burst so neighbouring states differ by one bit
  typedef enum logic [2:0] {
    STOP     = 3'b000,
    HS_RQST  = 3'b001,
    HS_PREP  = 3'b011,
    HS_ZERO  = 3'b010,
    HS_SEND  = 3'b110,
    HS_TRAIL = 3'b111,
    HS_EXIT  = 3'b101
  } lane_state_t;

  // LP levels packed as {Dp, Dn}
  typedef logic [1:0] lp_level_t;
  localparam lp_level_t LP11 = 2'b11;
  localparam lp_level_t LP01 = 2'b01;
  localparam lp_level_t LP00 = 2'b00;

  localparam int DEF_LPX_CYC   = 5;
  localparam int DEF_PREP_CYC  = 4;
  localparam int DEF_ZERO_CYC  = 10;
  localparam int DEF_TRAIL_CYC = 6;
  localparam int DEF_EXIT_CYC  = 8;
  localparam int DEF_CNT_W     = 8;

  function automatic logic is_timed(input lane_state_t s);
    return s inside {HS_RQST, HS_PREP, HS_ZERO, HS_TRAIL, HS_EXIT};
  endfunction

  // While the HS driver owns the lane the LP drivers sit at LP-00
  function automatic lp_level_t lp_level_of(input lane_state_t s);
    case (s)
      HS_RQST:                             return LP01;
      HS_PREP, HS_ZERO, HS_SEND, HS_TRAIL: return LP00;
      default:                             return LP11;
    endcase
  endfunction

endpackage

// File: rtl/dphy_timing_cnt.sv
// Lane timing down-counter: loads N-1 on state entry, counts to zero.
// done is registered and is high exactly while the count is zero.
module dphy_timing_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      done <= (load_val == '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      done <= (cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/dphy_data_lane_seq.sv
// D-PHY data lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-ZERO -> burst -> TRAIL -> EXIT.
// Define DPHY_TIMING_REG_EN to take lane timing from cfg_* ports instead of parameters.
module dphy_data_lane_seq
  import dphy_lane_pkg::*;
#(
  parameter int LPX_CYC   = DEF_LPX_CYC,
  parameter int PREP_CYC  = DEF_PREP_CYC,
  parameter int ZERO_CYC  = DEF_ZERO_CYC,
  parameter int TRAIL_CYC = DEF_TRAIL_CYC,
  parameter int EXIT_CYC  = DEF_EXIT_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_request_hs,
  input  logic             serial_end,
`ifdef DPHY_TIMING_REG_EN
  input  logic [CNT_W-1:0] cfg_lpx,
  input  logic [CNT_W-1:0] cfg_prep,
  input  logic [CNT_W-1:0] cfg_zero,
  input  logic [CNT_W-1:0] cfg_trail,
  input  logic [CNT_W-1:0] cfg_exit,
`endif
  output logic             tx_ready_hs,
  output logic             hs_en,
  output logic             hs_drv_en,
  output logic             trail_active,
  output logic             lp_dp,
  output logic             lp_dn,
  output logic             busy
);

  lane_state_t      state, next_state;
  logic             load, cnt_done;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] lpx_ld, prep_ld, zero_ld, trail_ld, exit_ld;

`ifdef DPHY_TIMING_REG_EN
  // A zero cycle count is stretched to one cycle
  function automatic logic [CNT_W-1:0] cfg_load(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  assign lpx_ld   = cfg_load(cfg_lpx);
  assign prep_ld  = cfg_load(cfg_prep);
  assign zero_ld  = cfg_load(cfg_zero);
  assign trail_ld = cfg_load(cfg_trail);
  assign exit_ld  = cfg_load(cfg_exit);
`else
  assign lpx_ld   = CNT_W'(LPX_CYC - 1);
  assign prep_ld  = CNT_W'(PREP_CYC - 1);
  assign zero_ld  = CNT_W'(ZERO_CYC - 1);
  assign trail_ld = CNT_W'(TRAIL_CYC - 1);
  assign exit_ld  = CNT_W'(EXIT_CYC - 1);
`endif

  always_comb begin
    next_state = state;
    case (state)
      STOP:     if (tx_request_hs) next_state = HS_RQST;
      HS_RQST:  if (cnt_done) next_state = HS_PREP;
      HS_PREP:  if (cnt_done) next_state = HS_ZERO;
      HS_ZERO:  if (cnt_done) next_state = tx_request_hs ? HS_SEND : HS_TRAIL;
      HS_SEND:  if (!tx_request_hs && serial_end) next_state = HS_TRAIL;
      HS_TRAIL: if (cnt_done) next_state = HS_EXIT;
      HS_EXIT:  if (cnt_done) next_state = STOP;
      default:  next_state = STOP;
    endcase
  end

  // Counter is reloaded only on the edge that enters a timed state
  always_comb begin
    load_val = '0;
    case (next_state)
      HS_RQST:  load_val = lpx_ld;
      HS_PREP:  load_val = prep_ld;
      HS_ZERO:  load_val = zero_ld;
      HS_TRAIL: load_val = trail_ld;
      HS_EXIT:  load_val = exit_ld;
      default:  load_val = '0;
    endcase
    load = (next_state != state) && is_timed(next_state);
  end

  dphy_timing_cnt #(.CNT_W(CNT_W)) u_timing_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= STOP;
      hs_en          <= 1'b0;
      hs_drv_en      <= 1'b0;
      trail_active   <= 1'b0;
      {lp_dp, lp_dn} <= LP11;
      busy           <= 1'b0;
    end else begin
      state          <= next_state;
      hs_en          <= (next_state == HS_SEND);
      hs_drv_en      <= next_state inside {HS_ZERO, HS_SEND, HS_TRAIL};
      trail_active   <= (next_state == HS_TRAIL);
      {lp_dp, lp_dn} <= lp_level_of(next_state);
      busy           <= (next_state != STOP);
    end
  end

  assign tx_ready_hs = (state == HS_SEND) & tx_request_hs;

endmodule

// File: tb/tb_dphy_data_lane_seq.sv
// Scoreboard bench for dphy_data_lane_seq: a hand-written per-cycle timeline of expected
// lane outputs is queued up front and a negedge monitor pops and compares it.
module tb_dphy_data_lane_seq;

  logic clk = 1'b0;
  logic rst, tx_request_hs, serial_end;
  logic tx_ready_hs, hs_en, hs_drv_en, trail_active, lp_dp, lp_dn, busy;

  always #5 clk = ~clk;

  dphy_data_lane_seq dut (
    .clk           (clk),
    .rst           (rst),
    .tx_request_hs (tx_request_hs),
    .serial_end    (serial_end),
`ifdef DPHY_TIMING_REG_EN
    .cfg_lpx       (8'd5),
    .cfg_prep      (8'd4),
    .cfg_zero      (8'd10),
    .cfg_trail     (8'd6),
    .cfg_exit      (8'd8),
`endif
    .tx_ready_hs   (tx_ready_hs),
    .hs_en         (hs_en),
    .hs_drv_en     (hs_drv_en),
    .trail_active  (trail_active),
    .lp_dp         (lp_dp),
    .lp_dn         (lp_dn),
    .busy          (busy)
  );

  // Expected vectors: {busy, lp_dp, lp_dn, hs_drv_en, hs_en, trail_active, tx_ready_hs}
  localparam logic [6:0] ST = 7'b0110000;
  localparam logic [6:0] RQ = 7'b1010000;
  localparam logic [6:0] PR = 7'b1000000;
  localparam logic [6:0] ZE = 7'b1001000;
  localparam logic [6:0] SR = 7'b1001101;
  localparam logic [6:0] SN = 7'b1001100;
  localparam logic [6:0] TR = 7'b1001010;
  localparam logic [6:0] EX = 7'b1110000;

  typedef struct {
    int         cyc;
    logic [6:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_seg(input int first, input int n, input logic [6:0] v, input string name);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.cyc  = first + i;
      e.exp  = v;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  // LPX=5, PREP=4, ZERO=10 cycles starting at the request-sampling edge e0
  task automatic push_entry(input int e0);
    push_seg(e0,      5,  RQ, "hs_rqst");
    push_seg(e0 + 5,  4,  PR, "hs_prep");
    push_seg(e0 + 9,  10, ZE, "hs_zero");
  endtask

  task automatic wait_edge(input int k);
    wait (cyc >= k);
    #1;
  endtask

  // Inputs change just after edge k, so edge k+1 is the first to sample them
  task automatic apply_stimulus(input int k, input logic req, input logic se);
    wait_edge(k);
    tx_request_hs = req;
    serial_end    = se;
  endtask

  task automatic check_output();
    logic [6:0] act;
    act = {busy, lp_dp, lp_dn, hs_drv_en, hs_en, trail_active, tx_ready_hs};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d (now %0d): got %b expected %b",
                 e.name, e.cyc, cyc, act, e.exp);
      end
    end
  endtask

  always @(negedge clk) check_output();

  initial begin
    rst           = 1'b1;
    tx_request_hs = 1'b1;
    serial_end    = 1'b0;

    // Reset with request held, then a full burst; D = 31
    push_seg(1, 3, ST, "reset_stop");
    push_entry(4);
    push_seg(23, 7, SR, "send_ready");
    push_seg(30, 5, SN, "send_hold");
    push_seg(35, 6, TR, "trail");
    push_seg(41, 8, EX, "exit");
    push_seg(49, 2, ST, "idle_stop");
    // Two-cycle request pulse: empty burst
    push_entry(51);
    push_seg(70, 6, TR, "pulse_trail");
    push_seg(76, 8, EX, "pulse_exit");
    push_seg(84, 2, ST, "pulse_stop");
    // Back-to-back bursts with the request held through EXIT
    push_entry(87);
    push_seg(106, 1, SR, "b2b_send_ready");
    push_seg(107, 1, SN, "b2b_send_drop");
    push_seg(108, 6, TR, "b2b_trail");
    push_seg(114, 8, EX, "b2b_exit");
    push_seg(122, 1, ST, "b2b_one_stop");
    push_seg(123, 5, RQ, "b2b_rqst2");
    push_seg(128, 4, PR, "b2b_prep2");
    push_seg(132, 3, ZE, "b2b_zero2");
    // Reset asserted mid HS_ZERO, then a fresh burst
    push_seg(135, 3, ST, "rst_in_zero");
    push_entry(138);
    push_seg(157, 1, SR, "post_rst_send");
    push_seg(158, 1, SN, "post_rst_drop");
    push_seg(159, 6, TR, "post_rst_trail");
    push_seg(165, 8, EX, "post_rst_exit");
    push_seg(173, 3, ST, "final_stop");

    wait_edge(3);
    rst = 1'b0;

    apply_stimulus(30, 1'b0, 1'b0);
    apply_stimulus(34, 1'b0, 1'b1);
    apply_stimulus(35, 1'b0, 1'b0);

    apply_stimulus(50, 1'b1, 1'b0);
    apply_stimulus(52, 1'b0, 1'b0);

    apply_stimulus(86, 1'b1, 1'b0);
    apply_stimulus(107, 1'b0, 1'b1);
    apply_stimulus(110, 1'b1, 1'b0);

    wait_edge(135);
    rst = 1'b1;
    wait_edge(137);
    rst = 1'b0;

    apply_stimulus(158, 1'b0, 1'b1);
    apply_stimulus(159, 1'b0, 1'b0);

    wait_edge(176);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected finish by cycle 176", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
